vending_arbiter: RTL and testbench

VENDING_ARBITER -- requirements
Module: vending_arbiter

---
 rtl/vending_pkg.sv | 28 ++
 rtl/vending_arbiter_rr_picker.sv | 37 +++
 rtl/vending_arbiter.sv | 152 +++++++++++++++
 tb/tb_vending_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending arbiter.
//   state_e        : arbiter FSM states
//   BEV_*          : beverage codes returned by the vending core
//   BTN_*          : kiosk button encodings
//   clean_button() : maps the illegal button code to "no button"
package vending_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SESSION = 2'd1,
      ST_DRAIN   = 2'd2
   } state_e;

   localparam logic [31:0] BEV_NONE  = 32'd0;
   localparam logic [31:0] BEV_WATER = 32'd1;
   localparam logic [31:0] BEV_SODA  = 32'd2;

   localparam logic [1:0] BTN_NONE    = 2'd0;
   localparam logic [1:0] BTN_ILLEGAL = 2'd3;

   localparam int IDLE_CNT_W  = 16;
   localparam int DRAIN_CNT_W = 4;

   function automatic logic [1:0] clean_button(input logic [1:0] btn);
      return (btn == BTN_ILLEGAL) ? BTN_NONE : btn;
   endfunction

endpackage

// File: rtl/vending_arbiter_rr_picker.sv
// Round-robin picker: selects the first set request at or after ptr_i.
//   req_i   : request vector
//   ptr_i   : index with highest priority this round
//   gnt_o   : one-hot grant (all zero when no request)
//   idx_o   : binary index of the granted request
//   valid_o : at least one request present
module rr_picker #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             valid_o
);

   // Walk offsets from farthest to nearest so the nearest requester
   // (smallest offset from the pointer) is the last one written and wins.
   always_comb begin
      int pos;
      pos     = 0;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int off = N - 1; off >= 0; off--) begin
         pos = (int'(ptr_i) + off) % N;
         if (req_i[pos]) begin
            gnt_o      = '0;
            gnt_o[pos] = 1'b1;
            idx_o      = PTR_W'(pos);
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vending_arbiter.sv
// Shares one vending core between NUM_REQ kiosks, one session at a time.
//   clk, rst          : clock, asynchronous active-low reset
//   req_i             : per-kiosk session request (level)
//   coin_i, button_i  : per-kiosk coin value / beverage button
//   gnt_o             : one-hot session grant
//   change_o          : change for the granted kiosk (1-cycle latency)
//   beverage_o        : beverage for the granted kiosk (1-cycle latency)
//   done_o            : one-cycle end-of-session pulse
//   vm_coin_o/button_o: granted kiosk's coin/button forwarded to the core
//   vm_change_i/beverage_i : results reported by the core
// A session ends on a core result, on IDLE_TIMEOUT idle cycles, or when the
// granted kiosk drops its request; DRAIN_CYCLES dead cycles follow.
module vending_arbiter
   import vending_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int IDLE_TIMEOUT = 255,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0][7:0]   coin_i,
   input  logic [NUM_REQ-1:0][1:0]   button_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0][31:0]  change_o,
   output logic [NUM_REQ-1:0][31:0]  beverage_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic [7:0]                vm_coin_o,
   output logic [1:0]                vm_button_o,
   input  logic [31:0]               vm_change_i,
   input  logic [31:0]               vm_beverage_i
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [IDLE_CNT_W-1:0]  TIMEOUT    = IDLE_CNT_W'(IDLE_TIMEOUT);
   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

   state_e                     state_q, state_d;
   logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]           idx_q, idx_d;
   logic [NUM_REQ-1:0]         gnt_q, gnt_d;
   logic [NUM_REQ-1:0]         done_q, done_d;
   logic [IDLE_CNT_W-1:0]      idle_q, idle_d;
   logic [DRAIN_CNT_W-1:0]     drain_q, drain_d;
   logic [NUM_REQ-1:0][31:0]   change_q, change_d;
   logic [NUM_REQ-1:0][31:0]   bev_q, bev_d;

   logic [NUM_REQ-1:0]         pick_gnt;
   logic [PTR_W-1:0]           pick_idx;
   logic                       pick_valid;

   logic [7:0]                 sel_coin;
   logic [1:0]                 sel_btn;
   logic                       active, complete, timeout, withdraw;
   logic [IDLE_CNT_W-1:0]      idle_inc;
   logic [PTR_W-1:0]           next_ptr;

   rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_picker (
      .req_i   (req_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Raw button counts as activity even when illegal: the customer is present.
   assign sel_coin = coin_i[idx_q];
   assign sel_btn  = button_i[idx_q];
   assign active   = (sel_coin != 8'd0) || (sel_btn != 2'd0);
   assign idle_inc = (&idle_q) ? idle_q : idle_q + 1'b1;
   assign complete = (vm_change_i != 32'd0) || (vm_beverage_i != 32'd0);
   // The idle cycle that brings the counter to IDLE_TIMEOUT ends the session.
   assign timeout  = !active && (idle_inc >= TIMEOUT);
   assign withdraw = !req_i[idx_q];
   assign next_ptr = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      idx_d       = idx_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      idle_d      = idle_q;
      drain_d     = drain_q;
      change_d    = '0;
      bev_d       = '0;
      vm_coin_o   = 8'd0;
      vm_button_o = 2'd0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_SESSION;
               idx_d   = pick_idx;
               gnt_d   = pick_gnt;
               idle_d  = '0;
            end
         end
         ST_SESSION: begin
            vm_coin_o   = sel_coin;
            vm_button_o = clean_button(sel_btn);
            // Core results are captured every session cycle; outside a
            // completion they are zero, so timeout/withdraw leave 0 behind.
            change_d[idx_q] = vm_change_i;
            bev_d[idx_q]    = vm_beverage_i;
            idle_d          = active ? '0 : idle_inc;
            if (complete || timeout || withdraw) begin
               state_d  = ST_DRAIN;
               gnt_d    = '0;
               done_d   = gnt_q;
               drain_d  = '0;
               rr_ptr_d = next_ptr;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) state_d = ST_IDLE;
            else                       drain_d = drain_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         idx_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         idle_q   <= '0;
         drain_q  <= '0;
         change_q <= '0;
         bev_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         idle_q   <= idle_d;
         drain_q  <= drain_d;
         change_q <= change_d;
         bev_q    <= bev_d;
      end
   end

   assign gnt_o      = gnt_q;
   assign done_o     = done_q;
   assign change_o   = change_q;
   assign beverage_o = bev_q;

endmodule

// File: tb/tb_vending_arbiter.sv
// Randomized + directed bench for vending_arbiter (2 kiosks, timeout 8,
// drain 2) against a transaction-level reference model.
module tb_vending_arbiter;

   localparam int N  = 2;
   localparam int TO = 8;
   localparam int DR = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N-1:0]      req_i = '0;
   logic [N-1:0][7:0] coin_i = '0;
   logic [N-1:0][1:0] button_i = '0;
   logic [N-1:0]      gnt_o;
   logic [N-1:0][31:0] change_o;
   logic [N-1:0][31:0] beverage_o;
   logic [N-1:0]      done_o;
   logic [7:0]        vm_coin_o;
   logic [1:0]        vm_button_o;
   logic [31:0]       vm_change_i = '0;
   logic [31:0]       vm_beverage_i = '0;

   vending_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TO), .DRAIN_CYCLES(DR)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req_i),
      .coin_i        (coin_i),
      .button_i      (button_i),
      .gnt_o         (gnt_o),
      .change_o      (change_o),
      .beverage_o    (beverage_o),
      .done_o        (done_o),
      .vm_coin_o     (vm_coin_o),
      .vm_button_o   (vm_button_o),
      .vm_change_i   (vm_change_i),
      .vm_beverage_i (vm_beverage_i)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the machine, whose turn is next, how long the
   // owner has been quiet, how many dead cycles remain before arbitration.
   int                 m_owner = -1;
   int                 m_ptr   = 0;
   int                 m_quiet = 0;
   int                 m_hold  = 0;
   logic [N-1:0]       e_gnt   = '0;
   logic [N-1:0]       e_done  = '0;
   logic [N-1:0][31:0] e_chg   = '0;
   logic [N-1:0][31:0] e_bev   = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_quiet = 0; m_hold = 0;
      e_gnt = '0; e_done = '0; e_chg = '0; e_bev = '0;
   endtask

   task automatic model_next(input logic [N-1:0] rq, input logic [N-1:0][7:0] c,
                             input logic [N-1:0][1:0] b, input logic [31:0] vch,
                             input logic [31:0] vbv);
      bit act;
      e_done = '0; e_chg = '0; e_bev = '0;
      if (m_owner >= 0) begin
         e_chg[m_owner] = vch;
         e_bev[m_owner] = vbv;
         act = (c[m_owner] != 0) || (b[m_owner] != 0);
         m_quiet = act ? 0 : m_quiet + 1;
         if (vch != 0 || vbv != 0 || (!act && m_quiet >= TO) || !rq[m_owner]) begin
            e_done[m_owner] = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_hold  = DR;
         end
      end else if (m_hold > 0) begin
         m_hold--;
      end else begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (rq[i] && m_owner < 0) begin
               m_owner = i;
               m_quiet = 0;
            end
         end
      end
      e_gnt = '0;
      if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
   endtask

   // One clock cycle; entered with clk low, returns at the next falling edge.
   task automatic step(input logic [N-1:0] rq, input logic [7:0] c0, input logic [7:0] c1,
                       input logic [1:0] b0, input logic [1:0] b1,
                       input logic [31:0] vch, input logic [31:0] vbv);
      logic [7:0] ec;
      logic [1:0] eb;
      req_i = rq; coin_i[0] = c0; coin_i[1] = c1;
      button_i[0] = b0; button_i[1] = b1;
      vm_change_i = vch; vm_beverage_i = vbv;
      #1;
      ec = 8'd0; eb = 2'd0;
      if (m_owner >= 0) begin
         ec = coin_i[m_owner];
         eb = (button_i[m_owner] == 2'd3) ? 2'd0 : button_i[m_owner];
      end
      chk("vm_coin", 32'(vm_coin_o), 32'(ec));
      chk("vm_button", 32'(vm_button_o), 32'(eb));
      model_next(rq, coin_i, button_i, vch, vbv);
      @(posedge clk); #1;
      chk("gnt", 32'(gnt_o), 32'(e_gnt));
      chk("done", 32'(done_o), 32'(e_done));
      chk("change0", change_o[0], e_chg[0]);
      chk("change1", change_o[1], e_chg[1]);
      chk("bev0", beverage_o[0], e_bev[0]);
      chk("bev1", beverage_o[1], e_bev[1]);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, 32'(gnt_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_chg"}, change_o[0] | change_o[1], 32'd0);
      chk({tag, "_bev"}, beverage_o[0] | beverage_o[1], 32'd0);
      chk({tag, "_vmcoin"}, 32'(vm_coin_o), 32'd0);
      chk({tag, "_vmbtn"}, 32'(vm_button_o), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0; #1;
      chk_all_zero(tag);
      model_reset();
      @(posedge clk); #1;
      chk_all_zero({tag, "_held"});
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int k;
      bit seen;
      // Reset state
      @(negedge clk);
      do_reset("por");

      // Kiosk0 buys water for 50 cents
      step(2'b01, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
      chk("A_gnt", 32'(gnt_o), 32'h1);
      step(2'b01, 8'd50, 8'd0, 2'd1, 2'd0, 0, 0);
      step(2'b01, 8'd0, 8'd0, 2'd0, 2'd0, 0, 1);
      chk("A_done", 32'(done_o), 32'h1);
      chk("A_bev", beverage_o[0], 32'd1);
      chk("A_gnt_drop", 32'(gnt_o), 32'h0);
      step(2'b01, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
      step(2'b01, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
      chk("A_drain", 32'(gnt_o), 32'h0);
      step(2'b00, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);

      // Contention after reset: kiosk0, then kiosk1 (ignoring kiosk0's coin)
      @(negedge clk);
      do_reset("rst_b");
      step(2'b11, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
      chk("B_first", 32'(gnt_o), 32'h1);
      step(2'b11, 8'd0, 8'd0, 2'd2, 2'd0, 0, 2);
      for (int i = 0; i < DR + 1; i++) step(2'b11, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
      chk("B_second", 32'(gnt_o), 32'h2);
      step(2'b11, 8'd100, 8'd5, 2'd0, 2'd0, 0, 0);
      chk("B_isolate", 32'(vm_coin_o), 32'd5);
      step(2'b11, 8'd100, 8'd0, 2'd3, 2'd0, 0, 0);
      chk("B_isolate0", 32'(vm_coin_o), 32'd0);
      step(2'b11, 8'd0, 8'd0, 2'd0, 2'd0, 7, 0);
      chk("B_chg1", change_o[1], 32'd7);
      for (int i = 0; i < DR + 1; i++) step(2'b11, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
      chk("B_third", 32'(gnt_o), 32'h1);

      // Idle timeout on kiosk0
      k = 0; seen = 0;
      while (!seen && k < 20) begin
         k++;
         step(2'b01, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
         seen = done_o[0];
      end
      chk("C_latency", 32'(k), 32'(TO));
      chk("C_change", change_o[0], 32'd0);
      chk("C_gnt", 32'(gnt_o), 32'h0);
      for (int i = 0; i < DR + 1; i++) step(2'b10, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);

      // Refund on kiosk1
      chk("D_gnt", 32'(gnt_o), 32'h2);
      step(2'b10, 8'd0, 8'd25, 2'd0, 2'd0, 0, 0);
      step(2'b10, 8'd0, 8'd0, 2'd0, 2'd0, 25, 0);
      chk("D_done", 32'(done_o), 32'h2);
      chk("D_chg", change_o[1], 32'd25);
      step(2'b10, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
      chk("D_chg_gone", change_o[1], 32'd0);
      for (int i = 0; i < DR; i++) step(2'b00, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);

      // Reset during a session with a coin being forwarded
      step(2'b10, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
      chk("E_gnt", 32'(gnt_o), 32'h2);
      coin_i[1] = 8'd40; #1;
      chk("E_fwd", 32'(vm_coin_o), 32'd40);
      do_reset("E_abort");
      step(2'b11, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);
      chk("E_restart", 32'(gnt_o), 32'h1);
      step(2'b00, 8'd0, 8'd0, 2'd0, 2'd0, 0, 0);

      // Random traffic with shifting densities
      for (int seg = 0; seg < 4; seg++) begin
         for (int cyc = 0; cyc < 400; cyc++) begin
            logic [N-1:0] rq;
            logic [7:0]   c0, c1;
            logic [1:0]   b0, b1;
            logic [31:0]  vch, vbv;
            int req_pct, coin_pct, vm_pct;
            req_pct  = (seg == 0) ? 100 : (seg == 1) ? 85 : 95;
            coin_pct = (seg == 0) ? 5 : (seg == 2) ? 60 : 25;
            vm_pct   = (seg == 0) ? 2 : 8;
            rq[0] = ($urandom_range(0, 99) < req_pct);
            rq[1] = ($urandom_range(0, 99) < req_pct);
            c0 = ($urandom_range(0, 99) < coin_pct) ? 8'($urandom_range(1, 255)) : 8'd0;
            c1 = ($urandom_range(0, 99) < coin_pct) ? 8'($urandom_range(1, 255)) : 8'd0;
            b0 = ($urandom_range(0, 99) < coin_pct) ? 2'($urandom_range(1, 3)) : 2'd0;
            b1 = ($urandom_range(0, 99) < coin_pct) ? 2'($urandom_range(1, 3)) : 2'd0;
            vch = ($urandom_range(0, 99) < vm_pct) ? 32'($urandom_range(0, 200)) : 32'd0;
            vbv = ($urandom_range(0, 99) < vm_pct) ? 32'($urandom_range(0, 2)) : 32'd0;
            step(rq, c0, c1, b0, b1, vch, vbv);
            if (seg == 3 && cyc == 200) do_reset("rand_rst");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
